// File: rtl/calc_seq.sv
// Token sequencer for the 4-bit calculator: turns operand/operator tokens into
// held register writes, then waits for calc_done and returns the result register.
module calc_seq #(
    parameter int HOLD_CYC     = 3,
    parameter int GAP_CYC      = 3,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    // Token handshake: a token transfers on a cycle where tok_valid && tok_ready.
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic [1:0] tok_kind,
    input  logic [7:0] tok_data,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       err,
    output logic       expr_open,
    output logic       calc_write_vld,
    output logic       calc_read_en,
    output logic [6:0] calc_addr,
    output logic [7:0] calc_data_w,
    input  logic [7:0] calc_data_r,
    input  logic       calc_done
);

    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(DONE_TIMEOUT + 1);

    localparam logic [1:0] KIND_OPND = 2'd0;
    localparam logic [1:0] KIND_ADD  = 2'd1;
    localparam logic [1:0] KIND_SUB  = 2'd2;
    localparam logic [1:0] KIND_END  = 2'd3;

    localparam logic [6:0] ADDR_OPND = 7'h01;
    localparam logic [6:0] ADDR_OP   = 7'h02;
    localparam logic [6:0] ADDR_RES  = 7'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_WAIT_DONE,
        S_READ,
        S_CAPTURE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              expect_opnd_q, expect_opnd_d;
    logic              is_end_q, is_end_d;
    logic              expr_open_q, expr_open_d;
    logic              write_vld_q, write_vld_d;
    logic              read_en_q, read_en_d;
    logic              res_valid_q, res_valid_d;
    logic              err_q, err_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        data_w_q, data_w_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              tok_ok;

    assign tok_ready      = (state_q == S_IDLE) && rst_n;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign err            = err_q;
    assign expr_open      = expr_open_q;
    assign calc_write_vld = write_vld_q;
    assign calc_read_en   = read_en_q;
    assign calc_addr      = addr_q;
    assign calc_data_w    = data_w_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            expect_opnd_q <= 1'b1;
            is_end_q      <= 1'b0;
            expr_open_q   <= 1'b0;
            write_vld_q   <= 1'b0;
            read_en_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            data_w_q      <= '0;
            res_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            expect_opnd_q <= expect_opnd_d;
            is_end_q      <= is_end_d;
            expr_open_q   <= expr_open_d;
            write_vld_q   <= write_vld_d;
            read_en_q     <= read_en_d;
            res_valid_q   <= res_valid_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            data_w_q      <= data_w_d;
            res_data_q    <= res_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        to_cnt_d      = to_cnt_q;
        expect_opnd_d = expect_opnd_q;
        is_end_d      = is_end_q;
        expr_open_d   = expr_open_q;
        write_vld_d   = 1'b0;
        read_en_d     = 1'b0;
        res_valid_d   = 1'b0;
        err_d         = 1'b0;
        addr_d        = addr_q;
        data_w_d      = data_w_q;
        res_data_d    = res_data_q;
        tok_ok        = ((tok_kind == KIND_OPND) == expect_opnd_q);

        case (state_q)
            S_IDLE: begin
                if (tok_valid) begin
                    // A token that breaks the operand/operator alternation is
                    // swallowed without touching the calculator.
                    if (!tok_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d       = S_DRIVE;
                        write_vld_d   = 1'b1;
                        cnt_d         = CNT_W'(HOLD_CYC - 1);
                        is_end_d      = (tok_kind == KIND_END);
                        expect_opnd_d = (tok_kind == KIND_ADD) || (tok_kind == KIND_SUB);
                        case (tok_kind)
                            KIND_OPND: begin
                                addr_d      = ADDR_OPND;
                                data_w_d    = tok_data;
                                expr_open_d = 1'b1;
                            end
                            KIND_ADD: begin
                                addr_d   = ADDR_OP;
                                data_w_d = 8'h10;
                            end
                            KIND_SUB: begin
                                addr_d   = ADDR_OP;
                                data_w_d = 8'h20;
                            end
                            default: begin
                                addr_d      = ADDR_OP;
                                data_w_d    = 8'h30;
                                expr_open_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    write_vld_d = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    if (is_end_q) begin
                        state_d  = S_WAIT_DONE;
                        to_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (calc_done) begin
                    state_d   = S_READ;
                    read_en_d = 1'b1;
                    addr_d    = ADDR_RES;
                end else if (to_cnt_q == TO_W'(DONE_TIMEOUT)) begin
                    // Abandon the expression so the requester can start over.
                    state_d       = S_IDLE;
                    err_d         = 1'b1;
                    expect_opnd_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d       = S_IDLE;
                res_data_d    = calc_data_r;
                res_valid_d   = 1'b1;
                expect_opnd_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed token streams, a calculator stub, and a monitor
// that matches bus writes, reads, results and errors against an expected queue.
module tb_calc_seq;

    localparam int HOLD = 3;
    localparam int GAP  = 3;

    localparam logic [3:0] EV_WRITE  = 4'h1;
    localparam logic [3:0] EV_READ   = 4'h2;
    localparam logic [3:0] EV_RESULT = 4'h3;
    localparam logic [3:0] EV_ERR    = 4'h4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tok_valid = 1'b0;
    logic [1:0] tok_kind = 2'd0;
    logic [7:0] tok_data = 8'h00;
    logic       tok_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err;
    logic       expr_open;
    logic       calc_write_vld;
    logic       calc_read_en;
    logic [6:0] calc_addr;
    logic [7:0] calc_data_w;
    logic [7:0] stub_result = 8'h00;
    logic       stub_en = 1'b0;
    logic       stub_done = 1'b0;
    logic       early_done = 1'b0;
    wire        calc_done_w = stub_done | early_done;

    calc_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tok_valid      (tok_valid),
        .tok_ready      (tok_ready),
        .tok_kind       (tok_kind),
        .tok_data       (tok_data),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .err            (err),
        .expr_open      (expr_open),
        .calc_write_vld (calc_write_vld),
        .calc_read_en   (calc_read_en),
        .calc_addr      (calc_addr),
        .calc_data_w    (calc_data_w),
        .calc_data_r    (stub_result),
        .calc_done      (calc_done_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] kind, input logic [7:0] addr, input logic [7:0] data);
        exp_q.push_back({kind, addr, data});
    endtask

    task automatic pop_cmp(input string name, input logic [19:0] act);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got %0h expected no event (cycle %0d)", name, act, cyc);
        end else begin
            e = exp_q.pop_front();
            check(name, {12'h0, act}, {12'h0, e});
        end
    endtask

    // Monitor: everything is sampled on the falling edge.
    logic       prev_wv = 1'b0;
    logic       tracking = 1'b0;
    int         hold_len = 0;
    int         gap_left = 0;
    logic [6:0] lat_a = '0;
    logic [7:0] lat_d = '0;
    int         rd_cyc = -1;
    int         res_cyc = -1;
    int         err_cyc = -1;
    logic       err_rdy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (gap_left > 0) begin
                check("gap_low", {31'b0, calc_write_vld}, 32'd0);
                check("gap_addr", {25'b0, calc_addr}, {25'b0, lat_a});
                check("gap_data", {24'b0, calc_data_w}, {24'b0, lat_d});
                gap_left--;
            end
            if (calc_write_vld && !prev_wv) begin
                pop_cmp("write", {EV_WRITE, 1'b0, calc_addr, calc_data_w});
                lat_a    = calc_addr;
                lat_d    = calc_data_w;
                tracking = 1'b1;
                hold_len = 1;
            end else if (calc_write_vld && tracking) begin
                hold_len++;
                check("hold_addr", {25'b0, calc_addr}, {25'b0, lat_a});
                check("hold_data", {24'b0, calc_data_w}, {24'b0, lat_d});
            end else if (!calc_write_vld && prev_wv && tracking) begin
                check("hold_len", hold_len, HOLD);
                check("gap_addr", {25'b0, calc_addr}, {25'b0, lat_a});
                check("gap_data", {24'b0, calc_data_w}, {24'b0, lat_d});
                gap_left = GAP - 1;
                tracking = 1'b0;
            end
            if (calc_read_en === 1'b1) begin
                pop_cmp("read", {EV_READ, 1'b0, calc_addr, 8'h00});
                rd_cyc = cyc;
            end
            if (res_valid === 1'b1) begin
                pop_cmp("result", {EV_RESULT, 8'h00, res_data});
                res_cyc = cyc;
            end
            if (err === 1'b1) begin
                pop_cmp("err", {EV_ERR, 16'h0000});
                err_cyc = cyc;
                err_rdy = tok_ready;
            end
            if (!rst_n) begin
                tracking = 1'b0;
                gap_left = 0;
            end
            prev_wv = (calc_write_vld === 1'b1);
        end
    end

    // Calculator stub: once the end write has finished its hold, raise
    // calc_done for one cycle two cycles after the gap.
    initial begin
        forever begin
            @(negedge clk);
            if (stub_en && calc_write_vld && calc_addr == 7'h02 && calc_data_w == 8'h30) begin
                do @(negedge clk); while (calc_write_vld);
                repeat (4) @(posedge clk);
                #1 stub_done = 1'b1;
                @(posedge clk);
                #1 stub_done = 1'b0;
            end
        end
    end

    // Offer a token and wait (bounded) for it to be taken; returns the accept cycle.
    task automatic send(input logic [1:0] kind, input logic [7:0] data, output int acc);
        int n;
        n = 0;
        acc = -1;
        tok_valid = 1'b1;
        tok_kind  = kind;
        tok_data  = data;
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            if (tok_ready) acc = cyc;
            else n++;
        end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tok_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int a0, a1, a2, a3, x;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write_vld", {31'b0, calc_write_vld}, 32'd0);
        check("rst_read_en", {31'b0, calc_read_en}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_expr_open", {31'b0, expr_open}, 32'd0);
        check("rst_addr", {25'b0, calc_addr}, 32'h00);
        check("rst_data_w", {24'b0, calc_data_w}, 32'h00);
        check("rst_res_data", {24'b0, res_data}, 32'h00);
        check("rst_tok_ready", {31'b0, tok_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, tok_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 0x05 + 0x03 with tok_valid held high throughout.
        stub_en = 1'b1;
        stub_result = 8'h08;
        push(EV_WRITE, 8'h01, 8'h05);
        send(2'd0, 8'h05, a0);
        check("expr_open_set", {31'b0, expr_open}, 32'd1);
        push(EV_WRITE, 8'h02, 8'h10);
        send(2'd1, 8'h00, a1);
        push(EV_WRITE, 8'h01, 8'h03);
        send(2'd0, 8'h03, a2);
        push(EV_WRITE, 8'h02, 8'h30);
        push(EV_READ, 8'h04, 8'h00);
        push(EV_RESULT, 8'h00, 8'h08);
        send(2'd3, 8'h00, a3);
        check("expr_open_clr", {31'b0, expr_open}, 32'd0);
        idle();
        wait_drain(60);
        check("b2b_gap1", a1 - a0, 32'd7);
        check("b2b_gap2", a2 - a1, 32'd7);
        check("b2b_gap3", a3 - a2, 32'd7);
        check("read_latency", rd_cyc - a3, 32'd9);
        check("result_latency", res_cyc - a3, 32'd11);

        // Operator first, then two operands in a row, then a valid tail.
        stub_result = 8'h01;
        push(EV_ERR, 8'h00, 8'h00);
        send(2'd1, 8'h00, x);
        idle();
        push(EV_WRITE, 8'h01, 8'h02);
        send(2'd0, 8'h02, x);
        push(EV_ERR, 8'h00, 8'h00);
        send(2'd0, 8'h03, x);
        idle();
        push(EV_WRITE, 8'h02, 8'h20);
        send(2'd2, 8'h00, x);
        push(EV_WRITE, 8'h01, 8'h01);
        send(2'd0, 8'h01, x);
        push(EV_WRITE, 8'h02, 8'h30);
        push(EV_READ, 8'h04, 8'h00);
        push(EV_RESULT, 8'h00, 8'h01);
        send(2'd3, 8'h00, x);
        idle();
        wait_drain(60);

        // Sub path: 0x09 - 0x04.
        stub_result = 8'h05;
        push(EV_WRITE, 8'h01, 8'h09);
        send(2'd0, 8'h09, x);
        push(EV_WRITE, 8'h02, 8'h20);
        send(2'd2, 8'h00, x);
        push(EV_WRITE, 8'h01, 8'h04);
        send(2'd0, 8'h04, x);
        push(EV_WRITE, 8'h02, 8'h30);
        push(EV_READ, 8'h04, 8'h00);
        push(EV_RESULT, 8'h00, 8'h05);
        send(2'd3, 8'h00, x);
        idle();
        wait_drain(60);

        // Reset pulse during DRIVE of the second token.
        push(EV_WRITE, 8'h01, 8'h05);
        send(2'd0, 8'h05, x);
        push(EV_WRITE, 8'h02, 8'h10);
        send(2'd1, 8'h00, x);
        tok_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_write_vld", {31'b0, calc_write_vld}, 32'd0);
        check("mid_rst_read_en", {31'b0, calc_read_en}, 32'd0);
        check("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        check("mid_rst_expr_open", {31'b0, expr_open}, 32'd0);
        check("mid_rst_addr", {25'b0, calc_addr}, 32'h00);
        check("mid_rst_data_w", {24'b0, calc_data_w}, 32'h00);
        check("mid_rst_res_data", {24'b0, res_data}, 32'h00);
        check("mid_rst_tok_ready", {31'b0, tok_ready}, 32'd1);
        @(posedge clk);
        #1;
        push(EV_ERR, 8'h00, 8'h00);
        send(2'd1, 8'h00, x);
        idle();
        wait_drain(40);

        // calc_done stuck low after end; an early done pulse is ignored.
        stub_en = 1'b0;
        push(EV_WRITE, 8'h01, 8'h07);
        send(2'd0, 8'h07, x);
        early_done = 1'b1;
        @(posedge clk);
        #1 early_done = 1'b0;
        push(EV_WRITE, 8'h02, 8'h30);
        push(EV_ERR, 8'h00, 8'h00);
        send(2'd3, 8'h00, a3);
        idle();
        wait_drain(80);
        check("timeout_latency", err_cyc - a3, 32'd23);
        check("timeout_ready", {31'b0, err_rdy}, 32'd1);
        check("ready_after_timeout", {31'b0, tok_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
# calc_seq

Token-driven sequencer that drives the 4-bit calculator's register-write bus. It accepts a stream of expression tokens (operands and operators) from an upstream requester and turns each token into a held `write_vld` pulse with the correct address and data. After the end token it waits for `calc_done`, reads the result register at address 0x04, and returns the result to the requester. It sits between host or test logic and the calculator, and enforces the write-hold timing and token grammar the calculator relies on.

## Interface
- `HOLD_CYC`, default 3: cycles `calc_write_vld` is held high per write (min 3).
- `GAP_CYC`, default 3: cycles addr/data stay stable with `calc_write_vld` low after each write (min 2).
- `DONE_TIMEOUT`, default 15: max cycles spent in WAIT_DONE before an error is flagged.
- Clocking and reset are fixed: one clock; reset is synchronous and active-low.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous active-low reset.
- `tok_valid` in 1: token offered.
- `tok_ready` out 1: token accepted when `tok_valid && tok_ready`.
- `tok_kind` in 2: 0 = operand, 1 = add, 2 = sub, 3 = end.
- `tok_data` in 8: operand value; ignored for operator tokens.
- `res_valid` out 1: one-cycle pulse; `res_data` is valid.
- `res_data` out 8: result read from the calculator.
- `err` out 1: one-cycle pulse on grammar violation or timeout.
- `expr_open` out 1: an expression has started and its end has not yet been issued.
- `calc_write_vld` out 1: to calculator `write_vld`.
- `calc_read_en` out 1: to calculator `read_en`.
- `calc_addr` out 7: to calculator `addr`.
- `calc_data_w` out 8: to calculator `data_w`.
- `calc_data_r` in 8: from calculator `data_r`.
- `calc_done` in 1: from calculator `calc_done`.

## Operation
- **FSM states:** IDLE, DRIVE, SETTLE, WAIT_DONE, READ, CAPTURE.
- **`tok_ready`:** equals `(state == IDLE) && rst_n`.
- **Grammar.** The `expect_opnd` flag is 1 after reset.
  - Operand accepted only when `expect_opnd = 1`; it then clears the flag.
  - add/sub/end accepted only when `expect_opnd = 0`; add/sub set the flag.
  - Violating token: consumed, nothing written to the calculator, `err` pulses, state stays IDLE, flag unchanged.
- **Token mapping:**
  - Operand: addr 0x01, data = `tok_data`.
  - Add: addr 0x02, data 0x10.
  - Sub: addr 0x02, data 0x20.
  - End: addr 0x02, data 0x30.
- **Accept (IDLE).** Register `calc_addr`/`calc_data_w` and go to DRIVE.
- **DRIVE.** `calc_write_vld = 1` for exactly HOLD_CYC cycles, then SETTLE.
- **SETTLE.** `calc_write_vld = 0` for GAP_CYC cycles. Then go to WAIT_DONE if the token was end, else IDLE.
- **addr/data hold.** `calc_addr`/`calc_data_w` stay constant from accept until the next accept or READ; they are held in IDLE.
- **WAIT_DONE.** On `calc_done = 1`, go to READ. If the cycle count reaches DONE_TIMEOUT first: `err` pulse, go to IDLE, no result.
- **READ.** One cycle with `calc_read_en = 1` and `calc_addr = 0x04`.
- **CAPTURE.** One cycle; `res_data <= calc_data_r` and `res_valid <= 1`, visible the next cycle. Then IDLE, `expect_opnd = 1`.
- **`expr_open`:** set on an accepted first operand; cleared on acceptance of the end token.
- **Counters:**
  - One shared down-counter for HOLD/GAP.
  - One timeout counter, width `clog2(DONE_TIMEOUT+1)`.
  - No wrap: each counter is reloaded on state entry.
- **Reset mid-operation:** next edge returns the block to IDLE with all outputs 0 and `expect_opnd = 1`. The calculator is not told; the requester must restart the expression.

## Timing
- **Output registers:** all outputs are registered except `tok_ready`.
- **Reset values:** `calc_write_vld`, `calc_read_en`, `res_valid`, `err`, `expr_open` = 0; `calc_addr` = 0x00; `calc_data_w` = 0x00; `res_data` = 0x00.
- **Token accepted at cycle t:**
  - `calc_write_vld` high in cycles t+1 .. t+HOLD_CYC.
  - `calc_write_vld` low in t+HOLD_CYC+1 .. t+HOLD_CYC+GAP_CYC.
  - `tok_ready` high again at t+HOLD_CYC+GAP_CYC+1 (t+7 with defaults).
- **Readback, with `calc_done` first seen high in cycle d:**
  - READ in d+1.
  - CAPTURE in d+2.
  - `res_valid` high in d+3, coinciding with IDLE.
- **`err`:** pulses the cycle after the offending accept or the timeout expiry.
- **`calc_done` before WAIT_DONE:** ignored while the block is in any other state.

## Test plan
- **Sequence 0x05, add, 0x03, end; stub asserts `calc_done` 2 cycles after end SETTLE and drives `data_r` = 0x08:**
  - Four writes with addr/data 01/05, 02/10, 01/03, 02/30, each with `write_vld` high exactly 3 cycles.
  - One `read_en` at addr 0x04.
  - `res_valid` pulse with `res_data` = 0x08.
- **Back-to-back tokens with `tok_valid` held high:** accepts are exactly 7 cycles apart; addr/data never change while `write_vld` = 1 or during GAP.
- **Operator as the first token, then two operands in a row:**
  - `err` pulses for the operator and for the second operand.
  - No `write_vld` for either.
  - A following valid sequence completes normally.
- **End token with `calc_done` stuck 0:** `err` pulses 16 cycles after WAIT_DONE entry; no `read_en`; `tok_ready` returns to 1.
- **`rst_n` low for 1 cycle during DRIVE of the second token:** next cycle all outputs are 0 and `tok_ready` = 1; an operator token is then rejected with `err`.
- **Sub path, 0x09, sub, 0x04, end:** the write of addr 0x02 carries data 0x20; result 0x05 from the stub is returned.
